// File: rtl/pipe_cla_adder_if.sv
// Bus bundle for pipe_cla_adder: operands, handshakes and results.
// CLA_SUB_EN adds the Sub control bit, captured with the operands.
interface pipe_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
`ifdef CLA_SUB_EN
    logic             Sub;
`endif
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             GG;
    logic             PG;
    logic             Ovf;
    logic             out_valid;
    logic             out_ready;

`ifdef CLA_SUB_EN
    modport master (
        output A, B, Cin, Sub, in_valid, out_ready,
        input  in_ready, S, Cout, GG, PG, Ovf, out_valid
    );
    modport slave (
        input  A, B, Cin, Sub, in_valid, out_ready,
        output in_ready, S, Cout, GG, PG, Ovf, out_valid
    );
`else
    modport master (
        output A, B, Cin, in_valid, out_ready,
        input  in_ready, S, Cout, GG, PG, Ovf, out_valid
    );
    modport slave (
        input  A, B, Cin, in_valid, out_ready,
        output in_ready, S, Cout, GG, PG, Ovf, out_valid
    );
`endif
endinterface

// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder. The word is cut into STAGES slices;
// stage k adds slice k (4-bit CLA groups) using the carry registered by
// stage k-1. Operands are skewed through the pipe and partial sums are
// carried forward so every bit of a result leaves the last stage together.
// in_ready is a global pipeline enable; bubbles are not collapsed.
// Optional feature macro: CLA_SUB_EN (adds Sub: B inverted, Cin as borrow-in).
module pipe_cla_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pipe_cla_adder_if.slave bus
);
    localparam int SW   = WIDTH / STAGES;
    localparam int NG   = SW / 4;
    localparam int F_CO = SW;       // slice carry-out
    localparam int F_G  = SW + 1;   // slice generate
    localparam int F_P  = SW + 2;   // slice propagate
    localparam int F_CM = SW + 3;   // carry into slice MSB

    // Adds one slice with 4-bit lookahead groups. Returns
    // {carry_into_msb, P, G, carry_out, sum}.
    function automatic logic [SW+3:0] cla_slice(
        input logic [SW-1:0] a,
        input logic [SW-1:0] b,
        input logic          cin
    );
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW:0]   c;
        logic          grp_p;
        logic          blk_g;
        logic          blk_p;
        logic          term;
        logic          acc;
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        c[0]  = cin;
        blk_g = 1'b0;
        blk_p = 1'b1;
        acc   = 1'b0;
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < 4; i++) begin
                // generate terms of bits 0..i, each gated by the propagates above it
                acc = 1'b0;
                for (int m = 0; m <= i; m++) begin
                    term = g[4*j+m];
                    for (int n = m + 1; n <= i; n++) begin
                        term = term & p[4*j+n];
                    end
                    acc = acc | term;
                end
                // group carry-in passing all propagates 0..i
                term = c[4*j];
                for (int n = 0; n <= i; n++) begin
                    term = term & p[4*j+n];
                end
                c[4*j+i+1] = acc | term;
            end
            // after i=3, acc is exactly the group generate (no carry-in term)
            grp_p = &p[4*j +: 4];
            blk_g = acc | (grp_p & blk_g);
            blk_p = blk_p & grp_p;
        end
        return {c[SW-1], blk_p, blk_g, c[SW], p ^ c[SW-1:0]};
    endfunction

    logic                            en_s;
    logic [WIDTH-1:0]                b_eff_s;
    logic                            cin_eff_s;
    logic [SW+3:0]                   slice_s;

    logic [STAGES-1:0]               v_q,    v_d;
    logic [STAGES-1:0][WIDTH-1:0]    a_q,    a_d;
    logic [STAGES-1:0][WIDTH-1:0]    b_q,    b_d;
    logic [STAGES-1:0][WIDTH-1:0]    s_q,    s_d;
    logic [STAGES-1:0]               ci_q,   ci_d;
    logic [STAGES-1:0]               cout_q, cout_d;
    logic [STAGES-1:0]               gg_q,   gg_d;
    logic [STAGES-1:0]               pg_q,   pg_d;
    logic [STAGES-1:0]               ovf_q,  ovf_d;
    logic                            unused_ok_s;

`ifdef CLA_SUB_EN
    assign b_eff_s   = bus.B ^ {WIDTH{bus.Sub}};
    assign cin_eff_s = bus.Sub ? !bus.Cin : bus.Cin;
`else
    assign b_eff_s   = bus.B;
    assign cin_eff_s = bus.Cin;
`endif

    // One enable for the whole pipe: move when the output slot is free or being taken.
    assign en_s         = !v_q[STAGES-1] || bus.out_ready;
    assign bus.in_ready = en_s;

    // Next state of every stage: stage 0 from the bus, stage k from stage k-1.
    always_comb begin
        v_d     = v_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        ci_d    = ci_q;
        cout_d  = cout_q;
        gg_d    = gg_q;
        pg_d    = pg_q;
        ovf_d   = ovf_q;
        slice_s = '0;

        slice_s   = cla_slice(bus.A[SW-1:0], b_eff_s[SW-1:0], cin_eff_s);
        v_d[0]    = bus.in_valid;
        a_d[0]    = bus.A;
        b_d[0]    = b_eff_s;
        ci_d[0]   = cin_eff_s;
        s_d[0]    = '0;
        s_d[0][SW-1:0] = slice_s[SW-1:0];
        gg_d[0]   = slice_s[F_G];
        pg_d[0]   = slice_s[F_P];
        cout_d[0] = gg_d[0] | (pg_d[0] & ci_d[0]);
        ovf_d[0]  = slice_s[F_CM] ^ cout_d[0];

        for (int k = 1; k < STAGES; k++) begin
            slice_s   = cla_slice(a_q[k-1][k*SW +: SW], b_q[k-1][k*SW +: SW], cout_q[k-1]);
            v_d[k]    = v_q[k-1];
            a_d[k]    = a_q[k-1];
            b_d[k]    = b_q[k-1];
            ci_d[k]   = ci_q[k-1];
            s_d[k]    = s_q[k-1];
            s_d[k][k*SW +: SW] = slice_s[SW-1:0];
            gg_d[k]   = slice_s[F_G] | (slice_s[F_P] & gg_q[k-1]);
            pg_d[k]   = pg_q[k-1] & slice_s[F_P];
            cout_d[k] = gg_d[k] | (pg_d[k] & ci_d[k]);
            ovf_d[k]  = slice_s[F_CM] ^ cout_d[k];
        end
    end

    // Pipeline registers: cleared by reset, advance together on enable, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            ci_q   <= '0;
            cout_q <= '0;
            gg_q   <= '0;
            pg_q   <= '0;
            ovf_q  <= '0;
        end else if (en_s) begin
            v_q    <= v_d;
            a_q    <= a_d;
            b_q    <= b_d;
            s_q    <= s_d;
            ci_q   <= ci_d;
            cout_q <= cout_d;
            gg_q   <= gg_d;
            pg_q   <= pg_d;
            ovf_q  <= ovf_d;
        end else begin
            v_q    <= v_q;
            a_q    <= a_q;
            b_q    <= b_q;
            s_q    <= s_q;
            ci_q   <= ci_q;
            cout_q <= cout_q;
            gg_q   <= gg_q;
            pg_q   <= pg_q;
            ovf_q  <= ovf_q;
        end
    end

    // Results leave straight from the last stage registers.
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.S         = s_q[STAGES-1];
    assign bus.Cout      = cout_q[STAGES-1];
    assign bus.GG        = gg_q[STAGES-1];
    assign bus.PG        = pg_q[STAGES-1];
    assign bus.Ovf       = ovf_q[STAGES-1];

    // Operand bits behind their slice and early-stage overflow taps are never consumed.
    assign unused_ok_s = ^{a_q, b_q, ci_q, ovf_q};

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder (WIDTH=16, STAGES=4) with a
// plain-arithmetic reference model and an expected-result queue.
module tb_pipe_cla_adder;
    localparam int W  = 16;
    localparam int ST = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         gg;
        logic         pg;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    logic cur_sub;
    int   n_pass  = 0;
    int   n_total = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    pipe_cla_adder_if #(.WIDTH(W)) bus ();

`ifdef CLA_SUB_EN
    assign bus.Sub = cur_sub;
`endif

    pipe_cla_adder #(.WIDTH(W), .STAGES(ST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: word-level arithmetic on the effective operands.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        res_t         r;
        logic [W-1:0] be;
        logic         ce;
        logic [W:0]   full;
        logic [W:0]   nocarry;
        be      = sub ? ~b : b;
        ce      = sub ? ~cin : cin;
        full    = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, ce};
        nocarry = {1'b0, a} + {1'b0, be};
        r.s     = full[W-1:0];
        r.cout  = full[W];
        r.gg    = nocarry[W];
        r.pg    = ((a ^ be) == {W{1'b1}});
        r.ovf   = (a[W-1] == be[W-1]) && (r.s[W-1] != a[W-1]);
        return r;
    endfunction

    function automatic res_t observed();
        return {bus.S, bus.Cout, bus.GG, bus.PG, bus.Ovf};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = 16'h0000;
            1:       v = 16'hFFFF;
            2:       v = 16'h7FFF;
            3:       v = 16'h8000;
            default: v = 16'($urandom());
        endcase
        return v;
    endfunction

    // Drives one operand set now (caller sits away from the edge) and waits for its result.
    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic sub, output res_t got, output int lat);
        bus.A = a; bus.B = b; bus.Cin = cin; cur_sub = sub;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = observed();
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res_t got;
        res_t exp;
        int   lat;
        rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.A = '0; bus.B = '0; bus.Cin = 1'b0; cur_sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({bus.out_valid, observed(), bus.in_ready} !== {1'b0, 20'h00000, 1'b1}) begin
            $display("FAIL reset_state: got %h expected %h",
                     {bus.out_valid, observed(), bus.in_ready}, {1'b0, 20'h00000, 1'b1});
        end else n_pass++;
        // release and offer an operand for the very next rising edge
        rst_n = 1'b1;
        send_one(16'h1234, 16'h4321, 1'b1, 1'b0, got, lat);
        exp = model(16'h1234, 16'h4321, 1'b1, 1'b0);
        n_total++;
        if (lat !== ST) $display("FAIL first_edge_latency: got %0d expected %0d", lat, ST);
        else n_pass++;
        n_total++;
        if (got !== exp) $display("FAIL first_edge_result: got %h expected %h", got, exp);
        else n_pass++;
        idle(3);
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[5] = '{16'h000F, 16'hFFFF, 16'h7FFF, 16'h5555, 16'h5555};
        logic [W-1:0] tb[5] = '{16'h0001, 16'h0001, 16'h0001, 16'hAAAA, 16'hAAAA};
        logic         tc[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] ts[5] = '{16'h0010, 16'h0000, 16'h8000, 16'hFFFF, 16'h0000};
        logic         tco[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        res_t got;
        res_t exp;
        int   lat;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            send_one(ta[i], tb[i], tc[i], 1'b0, got, lat);
            exp = model(ta[i], tb[i], tc[i], 1'b0);
            n_total++;
            if (lat !== ST) $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, ST);
            else n_pass++;
            n_total++;
            if ({got.s, got.cout} !== {ts[i], tco[i]})
                $display("FAIL directed%0d_sum: got %h expected %h", i, {got.s, got.cout}, {ts[i], tco[i]});
            else n_pass++;
            n_total++;
            if (got !== exp) $display("FAIL directed%0d_flags: got %h expected %h", i, got, exp);
            else n_pass++;
            idle(2);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va[8];
        logic [W-1:0] vb[8];
        logic         vc[8];
        res_t got;
        res_t exp;
        int   sent = 0;
        int   rcvd = 0;
        int   first_c = -1;
        int   last_c = -1;
        for (int i = 0; i < 8; i++) begin
            va[i] = pick_operand(); vb[i] = pick_operand(); vc[i] = 1'($urandom_range(0, 1));
        end
        exp_q.delete();
        cur_sub = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 60 && rcvd < 8; c++) begin
            bus.out_ready = !(c >= 5 && c <= 7);
            if (sent < 8) begin
                bus.A = va[sent]; bus.B = vb[sent]; bus.Cin = vc[sent]; bus.in_valid = 1'b1;
            end else bus.in_valid = 1'b0;
            @(negedge clk);
            if (c >= 5 && c <= 7) begin
                n_total++;
                if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready_c%0d: got %b expected 0", c, bus.in_ready);
                else n_pass++;
            end
            if (bus.out_valid && bus.out_ready) begin
                got = observed();
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                n_total++;
                if (got !== exp) $display("FAIL b2b_result%0d: got %h expected %h", rcvd, got, exp);
                else n_pass++;
                if (first_c < 0) first_c = c;
                last_c = c;
                rcvd++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(va[sent], vb[sent], vc[sent], 1'b0));
                sent++;
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        n_total++;
        if (rcvd !== 8 || sent !== 8) $display("FAIL b2b_count: got %0d/%0d expected 8/8", rcvd, sent);
        else n_pass++;
        n_total++;
        if (first_c !== 4 || last_c !== 14)
            $display("FAIL b2b_timing: got first %0d last %0d expected first 4 last 14", first_c, last_c);
        else n_pass++;
        idle(5);
    endtask

    task automatic test_reset_inflight();
        int seen = 0;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.A = 16'($urandom()); bus.B = 16'($urandom()); bus.Cin = 1'b1; bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (bus.out_valid !== 1'b1) $display("FAIL inflight_held: got %b expected 1", bus.out_valid);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.out_valid, observed(), bus.in_ready} !== {1'b0, 20'h00000, 1'b1})
            $display("FAIL reset_discard: got %h expected %h",
                     {bus.out_valid, observed(), bus.in_ready}, {1'b0, 20'h00000, 1'b1});
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL no_stale_result: got %0d results expected 0", seen);
        else n_pass++;
        idle(1);
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        res_t got;
        res_t exp;
        int   sent = 0;
        int   rcvd = 0;
        exp_q.delete();
        @(posedge clk); #1;
        a = pick_operand(); b = pick_operand(); cin = 1'($urandom_range(0, 1)); sub = 1'b0;
`ifdef CLA_SUB_EN
        sub = 1'($urandom_range(0, 1));
`endif
        for (int c = 0; c < 200 && (c < 120 || exp_q.size() > 0); c++) begin
            bus.A = a; bus.B = b; bus.Cin = cin; cur_sub = sub;
            bus.in_valid  = (c < 120) && ($urandom_range(0, 9) < 7);
            bus.out_ready = (c >= 120) || ($urandom_range(0, 9) < 6);
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                got = observed();
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                n_total++;
                if (got !== exp) $display("FAIL random_result%0d: got %h expected %h", rcvd, got, exp);
                else n_pass++;
                rcvd++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                sent++;
                a = pick_operand(); b = pick_operand(); cin = 1'($urandom_range(0, 1));
`ifdef CLA_SUB_EN
                sub = 1'($urandom_range(0, 1));
`endif
            end
            @(posedge clk); #1;
        end
        n_total++;
        if (rcvd !== sent || exp_q.size() != 0)
            $display("FAIL random_count: got %0d expected %0d", rcvd, sent);
        else n_pass++;
        cur_sub = 1'b0;
        bus.out_ready = 1'b1;
        idle(3);
    endtask

`ifdef CLA_SUB_EN
    task automatic test_sub();
        res_t got;
        int   lat;
        @(negedge clk);
        send_one(16'h0005, 16'h0007, 1'b0, 1'b1, got, lat);
        n_total++;
        if ({got.s, got.cout} !== {16'hFFFE, 1'b0})
            $display("FAIL sub_5_minus_7: got %h expected %h", {got.s, got.cout}, {16'hFFFE, 1'b0});
        else n_pass++;
        cur_sub = 1'b0;
        idle(3);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_inflight();
        test_random();
`ifdef CLA_SUB_EN
        test_sub();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_cla_adder.md
PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/sum width in bits; legal values are multiples of 4*STAGES.
REQ-002 The block SHALL have parameter STAGES, default 4, meaning number of pipeline slices and register stages; legal values are 1..8.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, meaning reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port A, input, WIDTH bits, meaning operand A.
REQ-006 The block SHALL have port B, input, WIDTH bits, meaning operand B.
REQ-007 The block SHALL have port Cin, input, 1 bit, meaning carry-in.
REQ-008 The block SHALL have port in_valid, input, 1 bit, meaning A/B/Cin are valid.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts the input this cycle.
REQ-010 The block SHALL have port S, output, WIDTH bits, meaning the sum.
REQ-011 The block SHALL have port Cout, output, 1 bit, meaning carry-out of the MSB.
REQ-012 The block SHALL have port GG, output, 1 bit, meaning word-level group generate.
REQ-013 The block SHALL have port PG, output, 1 bit, meaning word-level group propagate.
REQ-014 The block SHALL have port Ovf, output, 1 bit, meaning two's-complement signed overflow.
REQ-015 The block SHALL have port out_valid, output, 1 bit, meaning S/Cout/GG/PG/Ovf hold a result.
REQ-016 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result this cycle.

Function
REQ-017 The block SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-018 The block SHALL drive in_ready = !out_valid || out_ready, which acts as a global pipeline enable; it SHALL NOT collapse bubbles.
REQ-019 When the enable is high, the block SHALL advance every stage's valid bit and data by one stage; when it is low, it SHALL hold all stage state unchanged.
REQ-020 The block SHALL split the word into STAGES slices of WIDTH/STAGES bits; stage k SHALL add slice k using 4-bit CLA groups with in-slice lookahead, taking the carry registered from stage k-1 (Cin for k=0).
REQ-021 The block SHALL skew the input (delay slice k by k cycles) and deskew the output so that all bits of one result emerge together.
REQ-022 The block SHALL use a latency of exactly STAGES cycles from acceptance to out_valid when out_ready stays high; throughput SHALL be 1 result per cycle.
REQ-023 The block SHALL accumulate GG and PG across slices as PG = AND of slice P, and GG = G_k | (P_k & GG_prev), starting from GG_prev = 0.
REQ-024 The block SHALL compute Cout = GG | (PG & Cin_eff) and Ovf = carry-into-MSB XOR Cout.
REQ-025 The block SHALL return all sums modulo 2^WIDTH; wrap-around is silent apart from Cout and Ovf.
REQ-026 The block SHALL keep results in acceptance order; a result SHALL never be lost or duplicated under any out_ready pattern.
REQ-027 On a simultaneous input accept and output take in the same cycle, both transfers SHALL occur.

Reset
REQ-028 While rst_n=0, the block SHALL clear all valid bits and drive S=0, Cout=0, GG=0, PG=0, Ovf=0 and out_valid=0; in_ready SHALL then read 1.
REQ-029 Asserting rst_n mid-operation SHALL discard all in-flight results immediately, with no partial result ever emitted.
REQ-030 After rst_n deasserts, the block SHALL accept input on the first rising edge.

Configuration
REQ-031 With CLA_SUB_EN defined, the block SHALL add input port Sub (1 bit, captured with the operands), compute B_eff = B XOR {WIDTH{Sub}} and Cin_eff = Sub ? !Cin : Cin (Cin acts as borrow-in), and define Cout=1 as "no borrow".
REQ-032 With CLA_SUB_EN undefined, the Sub port SHALL be absent, B_eff = B and Cin_eff = Cin (add only).

Verification (WIDTH=16, STAGES=4, out_ready=1 unless stated)
REQ-033 The bench SHALL cover: A=0x000F, B=0x0001, Cin=0 -> after 4 cycles S=0x0010, Cout=0, Ovf=0.
REQ-034 The bench SHALL cover: A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1, GG=1, PG=0; and A=0x7FFF, B=0x0001 -> S=0x8000, Ovf=1.
REQ-035 The bench SHALL cover: A=0x5555, B=0xAAAA with Cin=0 -> S=0xFFFF, PG=1, GG=0, Cout=0; with Cin=1 -> S=0x0000, Cout=1.
REQ-036 The bench SHALL cover: 8 back-to-back inputs with out_ready low for cycles 5-7 -> in_ready low while stalled, all 8 results correct and in order, none lost.
REQ-037 The bench SHALL cover: rst_n pulsed low with 3 results in flight -> out_valid=0 at once and no stale result after release.
REQ-038 The bench SHALL cover, with CLA_SUB_EN defined: Sub=1, A=0x0005, B=0x0007, Cin=0 -> S=0xFFFE, Cout=0.
